cluster_nonce_hub: RTL and testbench



---
 rtl/cluster_pkg.sv | 25 ++
 rtl/cluster_nonce_hub_if.sv | 25 ++
 rtl/nonce_fifo.sv | 61 ++++++
 rtl/cluster_nonce_hub.sv | 180 ++++++++++++++++++
 tb/tb_cluster_nonce_hub.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_pkg.sv
// Shared types and constants for the nonce collection hub.
//   ser_state_t     : serializer FSM states
//   clog2           : ceiling log2 used for pointer/count widths
//   BYTES_PER_NONCE : bytes per uplink frame
package cluster_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    WAIT
  } ser_state_t;

  localparam int unsigned BYTES_PER_NONCE = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cluster_nonce_hub_if.sv
// Miner-side and transmitter-side signals of the nonce hub.
//   golden_valid/golden_nonce : per-lane hit pulses and values
//   new_work                  : flush pulse for stale results
//   tx_busy/tx_start/tx_data  : byte handshake with the async transmitter
// master drives hits and tx_busy; slave is the hub.
interface cluster_nonce_hub_if #(
  parameter int unsigned LOCAL_MINERS = 4
);
  logic [LOCAL_MINERS-1:0]    golden_valid;
  logic [32*LOCAL_MINERS-1:0] golden_nonce;
  logic                       new_work;
  logic                       tx_busy;
  logic                       tx_start;
  logic [7:0]                 tx_data;

  modport master (
    output golden_valid, golden_nonce, new_work, tx_busy,
    input  tx_start, tx_data
  );

  modport slave (
    input  golden_valid, golden_nonce, new_work, tx_busy,
    output tx_start, tx_data
  );
endinterface

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with flush; first-word-fall-through read port.
//   clk, rst_n          : clock, async active-low reset
//   flush               : empties the FIFO (wins over push/pop)
//   push/push_data      : write; accepted when not full or popping same cycle
//   pop/pop_data        : read; pop_data shows the head entry
//   count, full, empty  : occupancy status
module nonce_fifo
  import cluster_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/cluster_nonce_hub.sv
// Golden-nonce collection and uplink stage for a cluster slave node.
// Captures per-lane hits into pending slots, arbitrates round-robin into a
// FIFO (dropping back-to-back duplicates) and sends each nonce MSB-first as
// a 4-byte frame to the UART transmitter.
//   hash_clk, reset_n  : clock, async active-low reset
//   bus (slave)        : hits, new_work, tx handshake
//   lane_nonce_start   : per-lane start nonces for the miners
//   fifo_count         : FIFO occupancy
//   overflow_count     : nonces lost to a full FIFO (saturating)
//   drop_count         : hits overwritten in an occupied slot (saturating)
module cluster_nonce_hub
  import cluster_pkg::*;
#(
  parameter int unsigned TOTAL_MINERS      = 2,
  parameter int unsigned LOCAL_MINERS      = 4,
  parameter logic [31:0] LOCAL_NONCE_START = 32'd1,
  parameter int unsigned FIFO_DEPTH        = 8
) (
  input  logic                       hash_clk,
  input  logic                       reset_n,
  cluster_nonce_hub_if.slave         bus,
  output logic [32*LOCAL_MINERS-1:0] lane_nonce_start,
  output logic [clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                overflow_count,
  output logic [15:0]                drop_count
);
  localparam int unsigned LW = (LOCAL_MINERS > 1) ? clog2(LOCAL_MINERS) : 1;

  if ((TOTAL_MINERS == 0) || ((TOTAL_MINERS & (TOTAL_MINERS - 1)) != 0)) begin : g_bad_stride
    $error("TOTAL_MINERS must be a power of two");
  end

  for (genvar i = 0; i < LOCAL_MINERS; i++) begin : g_start
    assign lane_nonce_start[32*i +: 32] = LOCAL_NONCE_START + 32'(i);
  end

  logic [LOCAL_MINERS-1:0] pend_flag;
  logic [31:0]             pend_val [LOCAL_MINERS];
  logic [LW-1:0]           ptr;
  logic [LW-1:0]           gnt_idx;
  logic [LW-1:0]           next_ptr;
  logic                    gnt_valid;
  logic [31:0]             gnt_nonce;
  logic                    last_valid;
  logic [31:0]             last_nonce;
  logic                    fifo_push;
  logic                    push_ok;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [31:0]             fifo_dout;
  int unsigned             drop_n;
  logic [31:0]             drop_sum;
  ser_state_t              state;
  logic [31:0]             shreg;
  logic [1:0]              byte_idx;

  // Round-robin: first pending lane at or after ptr.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < LOCAL_MINERS; k++) begin
      cand = (32'(ptr) + k) % LOCAL_MINERS;
      if (!gnt_valid && pend_flag[LW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = LW'(cand);
      end
    end
  end

  assign next_ptr  = (32'(gnt_idx) + 1 == LOCAL_MINERS) ? '0 : gnt_idx + 1'b1;
  assign gnt_nonce = pend_val[gnt_idx];
  assign fifo_push = gnt_valid && !bus.new_work && !(last_valid && gnt_nonce == last_nonce);
  assign push_ok   = fifo_push && (!fifo_full || fifo_pop);
  // No pop while flushing, so a flush never lets a queued frame slip out.
  assign fifo_pop  = (state == IDLE) && !fifo_empty && !bus.new_work;

  // A lane re-hit while being granted keeps the new value pending, no drop.
  always_comb begin
    drop_n = 0;
    for (int unsigned i = 0; i < LOCAL_MINERS; i++) begin
      if (bus.golden_valid[i] && pend_flag[i] && !(gnt_valid && 32'(gnt_idx) == i)) drop_n++;
    end
    if (bus.new_work) drop_n = 0;
    drop_sum = 32'(drop_count) + drop_n;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_flag  <= '0;
      for (int unsigned i = 0; i < LOCAL_MINERS; i++) pend_val[i] <= '0;
      ptr        <= '0;
      last_valid <= 1'b0;
      last_nonce <= '0;
    end else if (bus.new_work) begin
      pend_flag  <= '0;
      ptr        <= '0;
      last_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < LOCAL_MINERS; i++) begin
        if (bus.golden_valid[i]) begin
          pend_flag[i] <= 1'b1;
          pend_val[i]  <= bus.golden_nonce[32*i +: 32];
        end else if (gnt_valid && 32'(gnt_idx) == i) begin
          pend_flag[i] <= 1'b0;
        end
      end
      if (gnt_valid) ptr <= next_ptr;
      if (push_ok) begin
        last_valid <= 1'b1;
        last_nonce <= gnt_nonce;
      end
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_count <= '0;
      drop_count     <= '0;
    end else begin
      if (fifo_push && !push_ok && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 1'b1;
      drop_count <= (drop_sum > 32'hFFFF) ? 16'hFFFF : drop_sum[15:0];
    end
  end

  nonce_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (hash_clk),
    .rst_n     (reset_n),
    .flush     (bus.new_work),
    .push      (fifo_push),
    .push_data (gnt_nonce),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Serializer: GAP gives the transmitter a cycle to raise tx_busy.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      byte_idx     <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
    end else begin
      bus.tx_start <= 1'b0;
      case (state)
        IDLE: if (fifo_pop) begin
          shreg    <= fifo_dout;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: if (!bus.tx_busy) begin
          bus.tx_start <= 1'b1;
          bus.tx_data  <= shreg[31:24];
          shreg        <= {shreg[23:0], 8'h00};
          state        <= GAP;
        end
        GAP: state <= WAIT;
        WAIT: if (!bus.tx_busy) begin
          if (32'(byte_idx) == BYTES_PER_NONCE - 1) begin
            state <= IDLE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            state    <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cluster_nonce_hub.sv
// Scoreboard bench for cluster_nonce_hub: expected tx bytes are queued when
// hits are issued and a monitor compares every tx_start byte against them.
module tb_cluster_nonce_hub;
  logic        hash_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [127:0] lane_nonce_start;
  logic [3:0]   fifo_count;
  logic [15:0]  overflow_count;
  logic [15:0]  drop_count;

  cluster_nonce_hub_if #(.LOCAL_MINERS(4)) bus ();

  cluster_nonce_hub #(
    .TOTAL_MINERS      (2),
    .LOCAL_MINERS      (4),
    .LOCAL_NONCE_START (32'd1),
    .FIFO_DEPTH        (8)
  ) dut (
    .hash_clk         (hash_clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .lane_nonce_start (lane_nonce_start),
    .fifo_count       (fifo_count),
    .overflow_count   (overflow_count),
    .drop_count       (drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  // Transmitter model: busy for 10 cycles after each byte, or held high.
  int unsigned busy_cnt  = 0;
  logic        busy_hold = 1'b0;
  always @(posedge hash_clk) begin
    if (bus.tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = busy_hold || (busy_cnt != 0);

  logic [7:0]  exp_q [$];
  logic [7:0]  exp_byte;
  int unsigned seen_bytes = 0;
  int          total  = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge hash_clk) begin
    if (reset_n && bus.tx_start) begin
      seen_bytes++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL tx_byte: got unexpected byte %02h, expected none", bus.tx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("tx_byte", 32'(bus.tx_data), 32'(exp_byte));
      end
    end
  end

  function automatic logic [127:0] pack4(input logic [31:0] n0, n1, n2, n3);
    return {n3, n2, n1, n0};
  endfunction

  task automatic expect_frame(input logic [31:0] n);
    exp_q.push_back(n[31:24]);
    exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
  endtask

  task automatic sync();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [127:0] nonces);
    bus.golden_valid = mask;
    bus.golden_nonce = nonces;
    sync();
    bus.golden_valid = '0;
  endtask

  task automatic flush_work();
    bus.new_work = 1'b1;
    sync();
    bus.new_work = 1'b0;
  endtask

  task automatic wait_bytes(input int unsigned n, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (seen_bytes >= n) break;
      sync();
    end
    if (seen_bytes < n) begin
      total++;
      $display("FAIL wait_bytes: got %0d bytes, expected %0d", seen_bytes, n);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (exp_q.size() == 0) break;
      sync();
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (40) sync();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int unsigned mark;

  initial begin
    bus.golden_valid = '0;
    bus.golden_nonce = '0;
    bus.new_work     = 1'b0;
    repeat (3) sync();
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_overflow", 32'(overflow_count), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("lane0_start", lane_nonce_start[31:0], 32'd1);
    check("lane3_start", lane_nonce_start[127:96], 32'd4);
    reset_n = 1'b1;
    sync();

    // Single hit on lane 2, two-cycle capture/push latency.
    expect_frame(32'hDEADBEEF);
    pulse(4'b0100, pack4(0, 0, 32'hDEADBEEF, 0));
    sync();
    check("t1_count_after_push", 32'(fifo_count), 1);
    sync();
    check("t1_count_after_pop", 32'(fifo_count), 0);
    drain(300);
    check("t1_fifo_empty", 32'(fifo_count), 0);

    // Simultaneous hits on all lanes: lane order 0..3.
    flush_work();
    expect_frame(32'h11110000);
    expect_frame(32'h11110001);
    expect_frame(32'h11110002);
    expect_frame(32'h11110003);
    pulse(4'b1111, pack4(32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003));
    drain(1000);
    check("t2_drop", 32'(drop_count), 0);
    check("t2_fifo_empty", 32'(fifo_count), 0);

    // Lane 3 re-hit while still pending: overwritten value, one drop.
    flush_work();
    expect_frame(32'h22220000);
    expect_frame(32'h22220001);
    expect_frame(32'h22220002);
    expect_frame(32'h3333CAFE);
    pulse(4'b1111, pack4(32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003));
    pulse(4'b1000, pack4(0, 0, 0, 32'h3333CAFE));
    drain(1000);
    check("t2b_drop", 32'(drop_count), 1);

    // Duplicate suppression, then cleared by new_work.
    flush_work();
    expect_frame(32'h12345678);
    pulse(4'b0010, pack4(0, 32'h12345678, 0, 0));
    repeat (5) sync();
    pulse(4'b0010, pack4(0, 32'h12345678, 0, 0));
    drain(300);
    flush_work();
    expect_frame(32'h12345678);
    pulse(4'b0010, pack4(0, 32'h12345678, 0, 0));
    drain(300);

    // Overflow: first nonce moves to the shift register, 8 fill the FIFO, 2 lost.
    flush_work();
    busy_hold = 1'b1;
    for (int i = 1; i <= 9; i++) expect_frame(32'hA0000000 + 32'(i));
    for (int i = 1; i <= 11; i++) pulse(4'b0001, pack4(32'hA0000000 + 32'(i), 0, 0, 0));
    repeat (3) sync();
    check("t4_fifo_full", 32'(fifo_count), 8);
    check("t4_overflow", 32'(overflow_count), 2);
    busy_hold = 1'b0;
    drain(2000);
    check("t4_fifo_empty", 32'(fifo_count), 0);

    // Flush after the second byte: current frame completes, queue is gone.
    flush_work();
    mark = seen_bytes;
    expect_frame(32'hF0F00000);
    pulse(4'b1111, pack4(32'hF0F00000, 32'hF0F00001, 32'hF0F00002, 32'hF0F00003));
    wait_bytes(mark + 2, 200);
    check("t5_queued", 32'(fifo_count), 3);
    flush_work();
    check("t5_flushed", 32'(fifo_count), 0);
    drain(300);
    repeat (60) sync();
    check("t5_frame_bytes", seen_bytes - mark, 4);
    check("t5_fifo_empty", 32'(fifo_count), 0);

    // Reset during WAIT aborts the frame; FSM restarts from IDLE.
    mark = seen_bytes;
    exp_q.push_back(8'h5A);
    pulse(4'b0001, pack4(32'h5A5A1234, 0, 0, 0));
    wait_bytes(mark + 1, 200);
    repeat (2) sync();
    check("t6_overflow_before", 32'(overflow_count), 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_tx_start", 32'(bus.tx_start), 0);
    check("t6_tx_data", 32'(bus.tx_data), 0);
    check("t6_overflow", 32'(overflow_count), 0);
    check("t6_drop", 32'(drop_count), 0);
    check("t6_fifo", 32'(fifo_count), 0);
    repeat (3) sync();
    reset_n = 1'b1;
    sync();
    expect_frame(32'h0BADF00D);
    pulse(4'b0100, pack4(0, 0, 32'h0BADF00D, 0));
    drain(300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
